// File: rtl/pid_pwm_gen.sv
// ----------------------------------------------------------------------------
// pid_pwm_gen
//
// Purpose:
//   Downstream stage of the PID AHB wrapper. Turns the two signed PID duty
//   words into two edge-aligned PWM outputs on HCLK. Duty words land in a
//   shadow pair first and only become active at a PWM period boundary, so a
//   pulse is never torn by a mid-period update. Duties outside [0, period]
//   are clipped and flagged for the period in which they are active.
//
// Ports:
//   HCLK          in   clock
//   HRESETn       in   asynchronous active-low reset
//   enable        in   1 = run, 0 = counter held at 0 and outputs low
//   period_in     in   requested period in HCLK cycles, taken at a boundary
//   duty0_in      in   channel 0 duty, signed HCLK counts
//   duty1_in      in   channel 1 duty, signed HCLK counts
//   duty_valid    in   strobe: copy duty0_in/duty1_in into the shadow pair
//   pwm0, pwm1    out  registered PWM outputs (lag the counter by one cycle)
//   period_start  out  pulse in the first cycle (cnt == 0) of each period
//   load_ack      out  pulse after a pending shadow pair became active
//   sat0, sat1    out  active duty of that channel was clipped
// ----------------------------------------------------------------------------
module pid_pwm_gen #(
   parameter int DUTY_W  = 25,
   parameter int CNT_W   = 16,
   parameter int PER_RST = 1000
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic                     enable,
   input  logic [CNT_W-1:0]         period_in,
   input  logic signed [DUTY_W-1:0] duty0_in,
   input  logic signed [DUTY_W-1:0] duty1_in,
   input  logic                     duty_valid,
   output logic                     pwm0,
   output logic                     pwm1,
   output logic                     period_start,
   output logic                     load_ack,
   output logic                     sat0,
   output logic                     sat1
);

   // Clip a signed duty into [0, per]. Result is {clipped_flag, value}.
   // Both operands are widened to DUTY_W+1 signed so the period is always
   // treated as a non-negative magnitude.
   function automatic logic [CNT_W:0] sat_duty(
      input logic signed [DUTY_W-1:0] duty,
      input logic [CNT_W-1:0]         per
   );
      logic signed [DUTY_W:0] d_w;
      logic signed [DUTY_W:0] p_w;
      d_w = {duty[DUTY_W-1], duty};
      p_w = {{(DUTY_W+1-CNT_W){1'b0}}, per};
      if (d_w[DUTY_W]) begin
         sat_duty = {1'b1, {CNT_W{1'b0}}};
      end else if (d_w > p_w) begin
         sat_duty = {1'b1, per};
      end else begin
         sat_duty = {1'b0, duty[CNT_W-1:0]};
      end
   endfunction

   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         per_act;
   logic                     fresh;      // next running edge must be a boundary
   logic signed [DUTY_W-1:0] shadow0;
   logic signed [DUTY_W-1:0] shadow1;
   logic                     pending;
   logic [CNT_W-1:0]         act0;
   logic [CNT_W-1:0]         act1;

   logic             per_ok;
   logic             run;
   logic             wrap;
   logic             boundary;
   logic             new_ok;
   logic [CNT_W:0]   sat_res0;
   logic [CNT_W:0]   sat_res1;

   // ---- boundary decode ------------------------------------------------------
   // A boundary is either the natural wrap of a running counter or the first
   // running edge after enable was low, after reset, or after a degenerate
   // period. In the latter case the counter simply stays at 0.
   always_comb begin
      per_ok   = (per_act > CNT_W'(1));
      run      = enable && per_ok;
      wrap     = (cnt == per_act - 1'b1);
      boundary = run && (fresh || wrap);
      new_ok   = (period_in > CNT_W'(1));
      // Active duties are clipped against the period that starts on this edge.
      sat_res0 = sat_duty(shadow0, period_in);
      sat_res1 = sat_duty(shadow1, period_in);
   end

   // ---- period counter -------------------------------------------------------
   // While the period is degenerate the request is re-sampled every cycle and
   // fresh stays set, so a later valid period restarts through a boundary.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt     <= '0;
         per_act <= CNT_W'(PER_RST);
         fresh   <= 1'b1;
      end else if (!enable) begin
         cnt     <= '0;
         fresh   <= 1'b1;
      end else if (!per_ok) begin
         cnt     <= '0;
         per_act <= period_in;
         fresh   <= 1'b1;
      end else if (boundary) begin
         cnt     <= '0;
         per_act <= period_in;
         fresh   <= 1'b0;
      end else begin
         cnt     <= cnt + 1'b1;
      end
   end

   // ---- shadow capture -------------------------------------------------------
   // A strobe on the boundary edge wins over the boundary clearing pending:
   // the boundary consumed the prior shadow, the new pair waits one period.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         shadow0 <= '0;
         shadow1 <= '0;
         pending <= 1'b0;
      end else if (duty_valid) begin
         shadow0 <= duty0_in;
         shadow1 <= duty1_in;
         pending <= 1'b1;
      end else if (boundary) begin
         pending <= 1'b0;
      end
   end

   // ---- active duty and saturation flags -------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         act0 <= '0;
         act1 <= '0;
         sat0 <= 1'b0;
         sat1 <= 1'b0;
      end else if (boundary) begin
         act0 <= sat_res0[CNT_W-1:0];
         act1 <= sat_res1[CNT_W-1:0];
         sat0 <= sat_res0[CNT_W];
         sat1 <= sat_res1[CNT_W];
      end
   end

   // ---- registered outputs ---------------------------------------------------
   // fresh masks the compare so the edge that starts a period after an idle
   // spell cannot emit a fragment of the stale active duty. A boundary into a
   // degenerate period does not announce a period start.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pwm0         <= 1'b0;
         pwm1         <= 1'b0;
         period_start <= 1'b0;
         load_ack     <= 1'b0;
      end else begin
         pwm0         <= run && !fresh && (cnt < act0);
         pwm1         <= run && !fresh && (cnt < act1);
         period_start <= boundary && new_ok;
         load_ack     <= boundary && pending;
      end
   end

endmodule

// File: tb/tb_pid_pwm_gen.sv
// ----------------------------------------------------------------------------
// tb_pid_pwm_gen
//
// Self-checking bench for pid_pwm_gen. A behavioural model tracks the position
// inside the current period, the period length, the shadow/active duty pairs
// and the pending flag as plain integers, and predicts every output cycle by
// cycle. Scenario tasks also check absolute pulse counts over whole periods.
// ----------------------------------------------------------------------------
module tb_pid_pwm_gen;
   localparam int DUTY_W  = 25;
   localparam int CNT_W   = 16;
   localparam int PER_RST = 1000;

   logic                     HCLK = 1'b0;
   logic                     HRESETn;
   logic                     enable;
   logic [CNT_W-1:0]         period_in;
   logic signed [DUTY_W-1:0] duty0_in;
   logic signed [DUTY_W-1:0] duty1_in;
   logic                     duty_valid;
   logic                     pwm0, pwm1, period_start, load_ack, sat0, sat1;

   int checks = 0;
   int errors = 0;

   pid_pwm_gen #(.DUTY_W(DUTY_W), .CNT_W(CNT_W), .PER_RST(PER_RST)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .enable(enable), .period_in(period_in),
      .duty0_in(duty0_in), .duty1_in(duty1_in), .duty_valid(duty_valid),
      .pwm0(pwm0), .pwm1(pwm1), .period_start(period_start),
      .load_ack(load_ack), .sat0(sat0), .sat1(sat1)
   );

   always #5 HCLK = ~HCLK;

   // ---------------- behavioural model ----------------
   int m_pos, m_per, m_sh0, m_sh1, m_act0, m_act1;
   bit m_pend, m_need;
   bit e_pwm0, e_pwm1, e_ps, e_la, e_sat0, e_sat1;

   function automatic int clip(input int d, input int p);
      if (d < 0) return 0;
      if (d > p) return p;
      return d;
   endfunction

   task automatic m_reset();
      m_pos = 0; m_per = PER_RST; m_sh0 = 0; m_sh1 = 0;
      m_act0 = 0; m_act1 = 0; m_pend = 0; m_need = 1;
      e_pwm0 = 0; e_pwm1 = 0; e_ps = 0; e_la = 0; e_sat0 = 0; e_sat1 = 0;
   endtask

   // One clock edge worth of behaviour, using the inputs present at the edge.
   task automatic m_step();
      bit live;
      live   = (enable == 1'b1) && (m_per >= 2) && !m_need;
      e_pwm0 = live && (m_pos < m_act0);
      e_pwm1 = live && (m_pos < m_act1);
      e_ps   = 0;
      e_la   = 0;
      if (enable == 1'b0) begin
         m_pos = 0; m_need = 1;
      end else if (m_per < 2) begin
         m_pos = 0; m_per = int'(period_in); m_need = 1;
      end else if (m_need || m_pos == m_per - 1) begin
         m_per  = int'(period_in);
         m_act0 = clip(m_sh0, m_per);
         m_act1 = clip(m_sh1, m_per);
         e_sat0 = (m_sh0 < 0) || (m_sh0 > m_per);
         e_sat1 = (m_sh1 < 0) || (m_sh1 > m_per);
         e_la   = m_pend;
         m_pend = 0;
         e_ps   = (m_per >= 2);
         m_pos  = 0;
         m_need = 0;
      end else begin
         m_pos++;
      end
      if (duty_valid == 1'b1) begin
         m_sh0  = int'(duty0_in);
         m_sh1  = int'(duty1_in);
         m_pend = 1;
      end
   endtask

   function automatic logic [5:0] obs();
      return {pwm0, pwm1, period_start, load_ack, sat0, sat1};
   endfunction

   function automatic logic [5:0] expv();
      return {e_pwm0, e_pwm1, e_ps, e_la, e_sat0, e_sat1};
   endfunction

   // Advance one clock; strobes last exactly one edge.
   task automatic step();
      @(posedge HCLK);
      m_step();
      #1;
      duty_valid = 1'b0;
   endtask

   function automatic logic signed [DUTY_W-1:0] rnd_duty();
      int x;
      if ($urandom_range(0, 7) == 0) x = int'($urandom) >>> 7;
      else                           x = int'($urandom_range(0, 20)) - 5;
      return DUTY_W'(x);
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      HRESETn = 1'b0; enable = 1'b0; period_in = 16'd10;
      duty0_in = '0; duty1_in = '0; duty_valid = 1'b0;
      m_reset();
      repeat (3) @(posedge HCLK);
      #1;
      checks++;
      if (obs() !== 6'b0) begin
         errors++; $display("FAIL reset_hold got=%b exp=%b", obs(), 6'b0);
      end
      HRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (obs() !== 6'b0) begin
            errors++; $display("FAIL reset_release i=%0d got=%b exp=%b", i, obs(), 6'b0);
         end
      end
   endtask

   task automatic test_basic();
      int n_la, n0, n1;
      n_la = 0; n0 = 0; n1 = 0;
      enable = 1'b1; period_in = 16'd10;
      step();
      checks++;
      if (period_start !== 1'b1) begin
         errors++; $display("FAIL basic_first_start got=%b exp=1", period_start);
      end
      for (int i = 0; i < 4; i++) step();
      duty0_in = 25'sd3; duty1_in = 25'sd7; duty_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         n_la += int'(load_ack);
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL basic_cycle i=%0d got=%b exp=%b", i, obs(), expv());
         end
      end
      checks++;
      if (n_la != 1) begin
         errors++; $display("FAIL basic_load_ack_count got=%0d exp=1", n_la);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         n0 += int'(pwm0); n1 += int'(pwm1);
      end
      checks++;
      if (n0 != 3 || n1 != 7) begin
         errors++; $display("FAIL basic_duty got=%0d/%0d exp=3/7", n0, n1);
      end
   endtask

   task automatic test_saturate();
      int n0, n1;
      n0 = 0; n1 = 0;
      duty0_in = -25'sd5; duty1_in = 25'sd25; duty_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL sat_cycle i=%0d got=%b exp=%b", i, obs(), expv());
         end
      end
      for (int i = 0; i < 10; i++) begin
         step();
         n0 += int'(pwm0); n1 += int'(pwm1);
      end
      checks++;
      if (n0 != 0 || n1 != 10) begin
         errors++; $display("FAIL sat_duty got=%0d/%0d exp=0/10", n0, n1);
      end
      checks++;
      if ({sat0, sat1} !== 2'b11) begin
         errors++; $display("FAIL sat_flags got=%b exp=11", {sat0, sat1});
      end
   endtask

   task automatic test_overwrite();
      int k, n_la, n0, n1;
      k = 0; n_la = 0; n0 = 0; n1 = 0;
      do begin step(); k++; end while (!e_ps && k < 30);
      checks++;
      if (!e_ps) begin
         errors++; $display("FAIL ovw_align got=timeout exp=period_start");
      end
      repeat (2) step();
      duty0_in = 25'sd2; duty1_in = 25'sd5; duty_valid = 1'b1;
      repeat (2) step();
      duty0_in = 25'sd8; duty1_in = 25'sd5; duty_valid = 1'b1;
      for (int i = 0; i < 25; i++) begin
         step();
         n_la += int'(load_ack);
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL ovw_cycle i=%0d got=%b exp=%b", i, obs(), expv());
         end
      end
      checks++;
      if (n_la != 1) begin
         errors++; $display("FAIL ovw_load_ack_count got=%0d exp=1", n_la);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         n0 += int'(pwm0); n1 += int'(pwm1);
      end
      checks++;
      if (n0 != 8 || n1 != 5) begin
         errors++; $display("FAIL ovw_duty got=%0d/%0d exp=8/5", n0, n1);
      end
   endtask

   task automatic test_coincident();
      int k, n_la, n0, n1;
      k = 0; n_la = 0;
      while (!(m_pos == m_per - 1 && !m_need) && k < 30) begin step(); k++; end
      duty0_in = 25'sd4; duty1_in = 25'sd6; duty_valid = 1'b1;
      step();
      checks++;
      if ({period_start, load_ack} !== 2'b10) begin
         errors++; $display("FAIL coin_edge got=%b exp=10", {period_start, load_ack});
      end
      for (int w = 0; w < 2; w++) begin
         n0 = 0; n1 = 0;
         for (int i = 0; i < 10; i++) begin
            step();
            n0 += int'(pwm0); n1 += int'(pwm1); n_la += int'(load_ack);
            checks++;
            if (obs() !== expv()) begin
               errors++; $display("FAIL coin_cycle w=%0d i=%0d got=%b exp=%b", w, i, obs(), expv());
            end
         end
         checks++;
         if (n0 != (w == 0 ? 8 : 4) || n1 != (w == 0 ? 5 : 6)) begin
            errors++; $display("FAIL coin_duty w=%0d got=%0d/%0d exp=%0d/%0d",
                               w, n0, n1, (w == 0 ? 8 : 4), (w == 0 ? 5 : 6));
         end
      end
      checks++;
      if (n_la != 1) begin
         errors++; $display("FAIL coin_load_ack_count got=%0d exp=1", n_la);
      end
   endtask

   task automatic test_period_change();
      int k, gap;
      k = 0;
      do begin step(); k++; end while (!e_ps && k < 30);
      repeat (3) step();
      period_in = 16'd4;
      for (int g = 0; g < 2; g++) begin
         gap = 0;
         do begin
            step(); gap++;
            checks++;
            if (obs() !== expv()) begin
               errors++; $display("FAIL per_cycle g=%0d got=%b exp=%b", g, obs(), expv());
            end
         end while (period_start !== 1'b1 && gap < 20);
         checks++;
         if (gap != (g == 0 ? 7 : 4)) begin
            errors++; $display("FAIL per_gap g=%0d got=%0d exp=%0d", g, gap, (g == 0 ? 7 : 4));
         end
      end
      checks++;
      if ({sat0, sat1} !== 2'b01) begin
         errors++; $display("FAIL per_resat got=%b exp=01", {sat0, sat1});
      end
   endtask

   task automatic test_reset_mid();
      int k, n1;
      k = 0; n1 = 0;
      do begin step(); k++; end while (!e_pwm1 && k < 20);
      checks++;
      if (pwm1 !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre got=%b exp=1", pwm1);
      end
      #2 HRESETn = 1'b0;
      #1;
      m_reset();
      checks++;
      if (obs() !== 6'b0) begin
         errors++; $display("FAIL rstmid_async got=%b exp=%b", obs(), 6'b0);
      end
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         n1 += int'(pwm1);
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL rstmid_cycle i=%0d got=%b exp=%b", i, obs(), expv());
         end
      end
      checks++;
      if (n1 != 0) begin
         errors++; $display("FAIL rstmid_no_pulse got=%0d exp=0", n1);
      end
   endtask

   task automatic test_enable_low();
      int k;
      k = 0;
      duty0_in = 25'sd2; duty1_in = 25'sd3; duty_valid = 1'b1;
      do begin step(); k++; end while (!e_pwm1 && k < 20);
      enable = 1'b0;
      step();
      checks++;
      if ({pwm0, pwm1, period_start} !== 3'b000) begin
         errors++; $display("FAIL en_low got=%b exp=000", {pwm0, pwm1, period_start});
      end
      for (int i = 0; i < 15; i++) begin
         if (i == 5) enable = 1'b1;
         step();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL en_cycle i=%0d got=%b exp=%b", i, obs(), expv());
         end
      end
   endtask

   task automatic test_degenerate();
      int n_ps;
      n_ps = 0;
      period_in = 16'd1;
      for (int i = 0; i < 40; i++) begin
         step();
         n_ps += int'(period_start);
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL degen_cycle i=%0d got=%b exp=%b", i, obs(), expv());
         end
      end
      checks++;
      if (n_ps != 0) begin
         errors++; $display("FAIL degen_no_start got=%0d exp=0", n_ps);
      end
      n_ps = 0;
      period_in = 16'd6;
      for (int i = 0; i < 20; i++) begin
         step();
         n_ps += int'(period_start);
      end
      checks++;
      if (n_ps != 4) begin
         errors++; $display("FAIL degen_restart got=%0d exp=4", n_ps);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 3) enable = ~enable;
         if ($urandom_range(0, 99) < 8) period_in = CNT_W'($urandom_range(0, 12));
         if ($urandom_range(0, 99) < 12) begin
            duty0_in = rnd_duty(); duty1_in = rnd_duty(); duty_valid = 1'b1;
         end
         step();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL rand_cycle i=%0d got=%b exp=%b", i, obs(), expv());
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_overwrite();
      test_coincident();
      test_period_change();
      test_reset_mid();
      test_enable_low();
      test_degenerate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
